// File: rtl/midi_transmitter_if.sv
// midi_transmitter_if
//   CPU-side MMIO bundle for the MIDI OUT serializer.
//   wr_en      one-cycle store strobe for the MIDI-out address
//   wr_data    packed message word {6'x, count[1:0], status, data1, data2}
//   status_rd  one-cycle strobe when the CPU reads the status address
//   status     {29'b0, overflow, full, busy}
//   busy       transmitter has queued or in-flight work
//   master = CPU / bus side, slave = transmitter side.
interface midi_transmitter_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        status_rd;
  logic [31:0] status;
  logic        busy;

  modport master (
    output wr_en, wr_data, status_rd,
    input  status, busy
  );

  modport slave (
    input  wr_en, wr_data, status_rd,
    output status, busy
  );
endinterface

// File: rtl/midi_transmitter.sv
// midi_transmitter
//   Queues packed MIDI message words in a small FIFO and shifts their bytes
//   out as 8N1 UART frames (idle high), status byte first.
//   Ports:
//     clock    system clock, all state changes on posedge
//     reset_n  asynchronous active-low reset; aborts any frame in flight
//     bus      MMIO bundle (store strobe/data, status read strobe, status, busy)
//     midi_out registered serial line
//   Parameters:
//     CLKS_PER_BIT  clock cycles per bit (>= 2)
//     DEPTH         FIFO depth in message words (power of 2, >= 2)
module midi_transmitter #(
  parameter int CLKS_PER_BIT = 1600,
  parameter int DEPTH        = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  midi_transmitter_if.slave    bus,
  output logic                 midi_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t state, state_n;

  // FIFO storage and pointers; the extra pointer bit tells full from empty
  logic [25:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, push, pop, ovf_set;
  logic [25:0]   head;

  // transmitter datapath
  logic [15:0]   msg;
  logic [1:0]    byte_cnt, byte_idx;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] timer;
  logic          bit_end, load_next, line, overflow, busy;
  logic          unused_bits;

  assign unused_bits = ^bus.wr_data[31:26];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // fullness is taken before any same-cycle pop, so a write that meets a
  // full FIFO is always dropped
  assign push    = bus.wr_en && (bus.wr_data[25:24] != 2'd0) && !full;
  assign ovf_set = bus.wr_en && (bus.wr_data[25:24] != 2'd0) && full;

  assign bit_end = (timer == TMAX);
  assign busy    = (state != IDLE) || !empty;

  assign bus.busy   = busy;
  assign bus.status = {29'b0, overflow, full, busy};

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.wr_data[25:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      // a new overflow wins over a same-cycle status read
      if (ovf_set)            overflow <= 1'b1;
      else if (bus.status_rd) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // next state; STOP chains straight into the next byte or message so
  // there is never an idle cycle between frames
  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    load_next = 1'b0;
    line      = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        line = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        line = shift[0];
        if (bit_end && bit_cnt == 3'd7) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (byte_idx != byte_cnt - 2'd1) begin
            load_next = 1'b1;
            state_n   = START;
          end else if (!empty) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // the line register lags the state by one cycle, which shifts every bit
  // equally and keeps each bit exactly CLKS_PER_BIT cycles wide
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      msg      <= '0;
      byte_cnt <= '0;
      byte_idx <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      timer    <= '0;
      midi_out <= 1'b1;
    end else begin
      midi_out <= line;
      if (pop) begin
        msg      <= head[15:0];
        byte_cnt <= head[25:24];
        byte_idx <= 2'd0;
        shift    <= head[23:16];
        bit_cnt  <= 3'd0;
        timer    <= '0;
      end else if (load_next) begin
        msg      <= {msg[7:0], 8'h00};
        byte_idx <= byte_idx + 2'd1;
        shift    <= msg[15:8];
        bit_cnt  <= 3'd0;
        timer    <= '0;
      end else if (state != IDLE) begin
        timer <= bit_end ? '0 : timer + TW'(1);
        if (state == DATA && bit_end) begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_transmitter.sv
// tb_midi_transmitter
//   Randomised and directed stimulus against a message-level reference model.
//   The model predicts, per clock edge, FIFO occupancy, flags and the start
//   cycle of every byte; a separate monitor decodes the serial line and
//   compares each decoded frame and the status word against the predictions.
module tb_midi_transmitter;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clock = 1'b0;
  logic reset_n;
  logic midi_out;

  midi_transmitter_if bus ();

  midi_transmitter #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .midi_out (midi_out)
  );

  always #5 clock = ~clock;

  // reference model state
  int          cyc = 0;
  logic [25:0] m_q [$];
  int          m_free = 0;
  int          m_last_pop = 0;
  logic        m_ovf = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_full = 1'b0;
  logic [7:0]  exp_byte [$];
  int          exp_start [$];

  // monitor / scoreboard state
  int          exp_rd = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        mon_active = 1'b0;
  int          mon_bit, mon_cnt, mon_start;
  logic        mon_cur, mon_bad;
  logic [7:0]  mon_byte;
  logic        final_req = 1'b0;
  logic        final_done = 1'b0;
  int          timeouts = 0;

  // The model treats the transmitter as a server that takes one message from
  // the queue whenever it is free and is then occupied for count*10*CPB cycles.
  // Its line output starts one cycle after the pop edge.
  always @(posedge clock or negedge reset_n) begin : model
    logic [25:0] w;
    int          pre;
    logic        ovf_set;
    if (!reset_n) begin
      m_q.delete();
      m_free = 0;
      m_ovf  = 1'b0;
      m_busy = 1'b0;
      m_full = 1'b0;
    end else begin
      cyc = cyc + 1;
      pre = m_q.size();
      ovf_set = 1'b0;
      if (bus.wr_en && bus.wr_data[25:24] != 2'd0) begin
        if (pre == DEPTH) ovf_set = 1'b1;
        else m_q.push_back(bus.wr_data[25:0]);
      end
      if (cyc >= m_free && pre > 0) begin
        w = m_q.pop_front();
        for (int j = 0; j < int'(w[25:24]); j++) begin
          exp_byte.push_back(w[23-8*j -: 8]);
          exp_start.push_back(cyc + 1 + j * FRAME);
        end
        m_free     = cyc + int'(w[25:24]) * FRAME;
        m_last_pop = cyc;
      end
      if (ovf_set)            m_ovf = 1'b1;
      else if (bus.status_rd) m_ovf = 1'b0;
      m_busy = (cyc < m_free) || (m_q.size() > 0);
      m_full = (m_q.size() == DEPTH);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h (cycle %0d)",
                  name, actual, expected, cyc);
  endtask

  // Monitor: checks status every cycle, and decodes the line sample by sample
  // so that bit widths, frame shape and frame start cycles are all checked.
  always @(negedge clock) begin : monitor
    if (!reset_n) begin
      mon_active = 1'b0;
      exp_rd = exp_byte.size();
      checkOutput("reset_line", {31'b0, midi_out}, 32'd1);
      checkOutput("reset_status", bus.status, 32'd0);
    end else begin
      checkOutput("status", bus.status, {29'b0, m_ovf, m_full, m_busy});
      checkOutput("busy", {31'b0, bus.busy}, {31'b0, m_busy});
      if (!mon_active && midi_out === 1'b0) begin
        mon_active = 1'b1;
        mon_bit    = 0;
        mon_cnt    = 0;
        mon_bad    = 1'b0;
        mon_start  = cyc;
      end
      if (mon_active) begin
        if (mon_cnt == 0) mon_cur = midi_out;
        else if (midi_out !== mon_cur) mon_bad = 1'b1;
        if (mon_cnt == CPB - 1) begin
          if (mon_bit == 0 && mon_cur !== 1'b0) mon_bad = 1'b1;
          if (mon_bit >= 1 && mon_bit <= 8) mon_byte[mon_bit-1] = mon_cur;
          if (mon_bit == 9) begin
            if (mon_cur !== 1'b1) mon_bad = 1'b1;
            mon_active = 1'b0;
            if (exp_rd >= exp_byte.size()) begin
              checkOutput("unexpected_frame", {24'b0, mon_byte}, 32'hFFFF_FFFF);
            end else begin
              checkOutput("frame_byte", {24'b0, mon_byte}, {24'b0, exp_byte[exp_rd]});
              checkOutput("frame_start_cycle", 32'(mon_start), 32'(exp_start[exp_rd]));
              checkOutput("frame_shape", {31'b0, mon_bad}, 32'd0);
              exp_rd++;
            end
          end
          mon_cnt = 0;
          mon_bit++;
        end else begin
          mon_cnt++;
        end
      end
      if (final_req && !final_done) begin
        checkOutput("frames_outstanding", 32'(exp_byte.size() - exp_rd), 32'd0);
        checkOutput("timeouts", 32'(timeouts), 32'd0);
        final_done = 1'b1;
      end
    end
  end

  // drive one cycle of strobes; callers start just after a falling edge so
  // back-to-back calls produce strobes on consecutive rising edges
  task automatic applyStimulus(input logic we, input logic [31:0] data, input logic rd);
    bus.wr_en     = we;
    bus.wr_data   = data;
    bus.status_rd = rd;
    @(negedge clock);
    bus.wr_en     = 1'b0;
    bus.status_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic waitIdle();
    int g = 0;
    while (m_busy && g < 5000) begin
      @(negedge clock);
      g++;
    end
    if (m_busy) timeouts++;
    idle(5);
  endtask

  task automatic waitCycle(input int target);
    int g = 0;
    while (cyc != target && g < 5000) begin
      @(negedge clock);
      g++;
    end
    if (cyc != target) timeouts++;
  endtask

  // Main sequence: directed cases from the block's behaviour, then a random
  // mix, then a reset that lands in the middle of a message.
  initial begin : stim
    logic [31:0] word;
    reset_n       = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_data   = 32'd0;
    bus.status_rd = 1'b0;
    #1 reset_n = 1'b0;
    idle(4);
    #1 reset_n = 1'b1;
    idle(5);

    $display("[TB] single note-on");
    applyStimulus(1'b1, 32'h0390_3C64, 1'b0);
    waitIdle();

    $display("[TB] byte counts");
    applyStimulus(1'b1, 32'h01F8_0000, 1'b0);
    waitIdle();
    applyStimulus(1'b1, 32'h02C0_0500, 1'b0);
    waitIdle();
    applyStimulus(1'b1, 32'h0090_3C64, 1'b0);
    idle(20);
    applyStimulus(1'b1, 32'hFE80_4040, 1'b0);
    waitIdle();

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 32'h0390_3C64, 1'b0);
    applyStimulus(1'b1, 32'h0380_3C00, 1'b0);
    waitIdle();

    $display("[TB] overflow and coincident events");
    applyStimulus(1'b1, 32'h0391_4070, 1'b0);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      word = {6'd0, 2'd3, 24'($urandom)};
      applyStimulus(1'b1, word, 1'b0);
    end
    idle(3);
    applyStimulus(1'b0, 32'd0, 1'b1);
    waitCycle(m_free - 1);
    applyStimulus(1'b1, 32'h0299_1122, 1'b0);
    applyStimulus(1'b1, 32'h01FA_0000, 1'b0);
    applyStimulus(1'b1, 32'h01FC_0000, 1'b1);
    idle(3);
    applyStimulus(1'b0, 32'd0, 1'b1);
    waitIdle();

    $display("[TB] random traffic");
    for (int i = 0; i < 30; i++) begin
      word = $urandom;
      word[25:24] = 2'($urandom_range(0, 3));
      applyStimulus(1'b1, word, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 4));
      else idle($urandom_range(10, 120));
      if ($urandom_range(0, 5) == 0) applyStimulus(1'b0, 32'd0, 1'b1);
    end
    waitIdle();
    applyStimulus(1'b0, 32'd0, 1'b1);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 32'h0390_3C64, 1'b0);
    idle(1);
    waitCycle(m_last_pop + 50);
    @(posedge clock);
    #1 reset_n = 1'b0;
    idle(3);
    #1 reset_n = 1'b1;
    idle(200);

    final_req = 1'b1;
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/midi_transmitter.md
# midi_transmitter

Memory-mapped MIDI OUT serializer: the transmit end of the MIDI link whose receive end feeds the MIDI-in MMIO register. The CPU stores a packed message word to the MIDI-out MMIO address. The block queues it in a small FIFO and shifts its bytes onto a 31250-baud UART line (8N1, idle high). Status is readable via a second MMIO address through the mmio read mux.

## Interface

- CLKS_PER_BIT, default 1600: clock cycles per MIDI bit (50 MHz / 31250); must be ≥ 2.
- DEPTH, default 4: message FIFO depth in words; power of 2, ≥ 2.

- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  one-cycle store strobe (mem write enable AND address == MIDI-out).
- wr_data  in  32  message word: [25:24] byte count, [23:16] status byte, [15:8] data1, [7:0] data2; [31:26] ignored.
- status_rd  in  1  one-cycle strobe when the CPU reads the status address; clears overflow.
- midi_out  out  1  serial MIDI line, registered, idle high.
- status  out  32  {29'b0, overflow, full, busy}.
- busy  out  1  high while the FIFO is non-empty or a frame is in progress.

## Operation

- **Reset values:** midi_out=1, busy=0, full=0, overflow=0, FIFO empty, FSM=IDLE, counters 0. Reset mid-frame aborts the frame immediately (line returns high asynchronously) and discards all queued messages.
- **Write acceptance:** wr_en with count ∈ {1,2,3} and FIFO not full pushes wr_data[25:0].
  - Count 0: the write is ignored; no push and no flag change.
  - wr_en while full: the word is dropped and overflow is set. Fullness is evaluated before any same-cycle pop, so the word is dropped even if a pop occurs that cycle.
- **Overflow flag:** sticky until status_rd. If status_rd and an overflowing write occur in the same cycle, overflow ends up 1.
- **Byte order:** [23:16] first, then [15:8], then [7:0], truncated to the count (count 1 → status byte only; count 2 → status, data1). No running-status compression; bytes are sent exactly as given.
- **Frame:** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- **FSM states:**
  - IDLE: line high. If FIFO non-empty → pop head, load byte index 0 → START.
  - START: drive 0 for CLKS_PER_BIT cycles → DATA.
  - DATA: drive shift[0] for CLKS_PER_BIT cycles and shift right; after the 8th bit → STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles. Then:
    - bytes remain in the current message → load next byte → START (no idle gap);
    - else if FIFO non-empty → pop → START directly (no idle cycle);
    - else → IDLE.
- **Byte count width:** 2 bits, byte index 2 bits, bit counter 3 bits. The bit timer width is clog2(CLKS_PER_BIT) and it wraps to 0 at CLKS_PER_BIT−1.
- **Busy:** busy = (FSM != IDLE) | ~empty. status[0]=busy, status[1]=full, status[2]=overflow.

## Timing

- A write accepted at edge k into an empty, idle block is visible in the FIFO at k+1. IDLE pops at edge k+1 and midi_out falls at edge k+2. Start-of-frame latency is 2 cycles.
- Frame length is exactly 10·CLKS_PER_BIT cycles. An n-byte message occupies n·10·CLKS_PER_BIT contiguous cycles.
- Back-to-back messages: the next start bit begins on the cycle after the last stop-bit cycle, with zero idle cycles.
- busy rises the cycle after the accepting edge. It falls on the cycle after the final stop bit completes with an empty FIFO.
- full asserts the cycle after the DEPTH-th outstanding word is pushed. It deasserts the cycle after the pop.
- status is combinational from registered flags. overflow set/clear takes effect on the edge of the triggering strobe.

## Test plan

- **Single note-on** (CLKS_PER_BIT=4): write 0x03_90_3C_64.
  - midi_out falls 2 cycles later; three 40-cycle frames follow, carrying 0x90, 0x3C, 0x64 LSB first.
  - Line is high and busy=0 on cycle 122 after the write.
- **Byte counts:**
  - Write 0x01_F8_00_00 → exactly one 40-cycle frame (0xF8).
  - Write 0x02_C0_05_00 → two frames (0xC0, 0x05).
  - Write 0x00_90_3C_64 → line stays high, busy stays 0.
- **Back-to-back:** push two 3-byte messages in consecutive cycles → six contiguous frames with no high gap between stop and start bits; busy continuously high for 240 cycles.
- **Overflow** (DEPTH=4): push 6 words during the first frame.
  - The first word goes to the shifter; 4 are queued; the 6th sets overflow=1.
  - Exactly 5 messages are transmitted.
  - status_rd clears overflow; full=1 only while 4 words are queued.
- **Reset mid-frame:** assert reset_n=0 during the DATA bits of the second byte → midi_out=1 with no clock edge, busy=0, FIFO empty; after release, no further bits are sent.
- **Simultaneous events:**
  - wr_en while full coincides with a pop → word dropped, overflow=1.
  - status_rd coincides with an overflowing write → overflow=1.
